// File: rtl/fetch_buffer.sv
// Instruction-fetch buffer: issues PC requests to imem and delivers {instr, pc} to decode.
// FETCH_BUF_PERF_EN adds the perf_stall_cnt / perf_flush_cnt counters.
module fetch_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    output logic            pc_en,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc
`ifdef FETCH_BUF_PERF_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned UW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] slot_pc    [DEPTH];
    logic [XLEN-1:0] slot_instr [DEPTH];
    logic [DEPTH-1:0] slot_alloc;
    logic [DEPTH-1:0] slot_fill;
    logic [PW-1:0]   alloc_ptr, fill_ptr, head_ptr;
    logic [UW-1:0]   used;
    // pend counts allocated-but-unfilled slots; drop_cnt counts squashed words still in flight
    logic [UW-1:0]   pend;
    logic [UW-1:0]   drop_cnt;

    logic req_fire, id_fire, rsp_keep, rsp_drop;

    always_comb begin
        imem_req_valid = ~rst & (used < UW'(DEPTH)) & (drop_cnt == '0) & ~flush;
        imem_req_addr  = pc;
        req_fire       = imem_req_valid & imem_req_ready;
        pc_en          = ~rst & (req_fire | flush);
        id_valid       = slot_alloc[head_ptr] & slot_fill[head_ptr];
        id_instr       = slot_instr[head_ptr];
        id_pc          = slot_pc[head_ptr];
        id_fire        = id_valid & id_ready;
        rsp_keep       = imem_rsp_valid & (drop_cnt == '0);
        rsp_drop       = imem_rsp_valid & (drop_cnt != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_pc[i]    <= '0;
                slot_instr[i] <= '0;
            end
            slot_alloc <= '0;
            slot_fill  <= '0;
            alloc_ptr  <= '0;
            fill_ptr   <= '0;
            head_ptr   <= '0;
            used       <= '0;
            pend       <= '0;
            drop_cnt   <= '0;
        end else if (flush) begin
            // Every word still owed by memory for a live slot becomes a word to discard.
            slot_alloc <= '0;
            slot_fill  <= '0;
            alloc_ptr  <= '0;
            fill_ptr   <= '0;
            head_ptr   <= '0;
            used       <= '0;
            pend       <= '0;
            drop_cnt   <= drop_cnt + pend - UW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                slot_pc[alloc_ptr]    <= pc;
                slot_alloc[alloc_ptr] <= 1'b1;
                slot_fill[alloc_ptr]  <= 1'b0;
                alloc_ptr             <= alloc_ptr + 1'b1;
            end
            if (rsp_keep) begin
                slot_instr[fill_ptr] <= imem_rsp_data;
                slot_fill[fill_ptr]  <= 1'b1;
                fill_ptr             <= fill_ptr + 1'b1;
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
            if (id_fire) begin
                slot_alloc[head_ptr] <= 1'b0;
                slot_fill[head_ptr]  <= 1'b0;
                head_ptr             <= head_ptr + 1'b1;
            end
            used <= used + UW'(req_fire) - UW'(id_fire);
            pend <= pend + UW'(req_fire) - UW'(rsp_keep);
        end
    end

`ifdef FETCH_BUF_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (id_ready & ~id_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (flush)                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule
